resource_arbiter_if: RTL and testbench
======================================

# resource_arbiter_if

Downstream neighbour of the pipeline top level. It consumes the validated 32-bit output stream, queues words in a small FIFO, and wins access to the shared resource through a request/grant arbiter. It drives each word to the resource, captures the resource's result after a fixed latency, and presents it as a one-cycle-valid result. It back-pressures the pipeline with a stall signal and supports flush and grant timeout.

## Interface
Parameters:
- DATA_W, 32, width of data, resource_input, resource_output and result.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RES_LAT, 2, cycles from the grant cycle to the cycle in which resource_output is valid; at least 1.
- GRANT_TO, 15, number of REQ cycles without a grant before the head word is dropped.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of queue and in-flight transaction.
- in_data  in  DATA_W  word from the upstream buffer stage.
- in_valid  in  1  in_data valid this cycle.
- stall_out  out  1  back-pressure to upstream stall management.
- arbiter_req  out  1  request for the shared resource.
- arbiter_grant  in  1  grant from the arbiter.
- resource_input  out  DATA_W  word driven to the resource.
- resource_output  in  DATA_W  resource result.
- result  out  DATA_W  captured resource result.
- result_valid  out  1  one-cycle pulse; result is valid.
- timeout_err  out  1  one-cycle pulse; head word dropped on grant timeout.
- overflow  out  1  sticky flag; a valid input was dropped because the FIFO was full.

## Operation
- **FIFO.** DEPTH entries with wrapping read/write pointers and a count of width log2(DEPTH)+1.
  - Push when in_valid and (count < DEPTH, or a pop happens in the same cycle).
  - If in_valid is high while full with no pop, the word is dropped and overflow is set. Only reset clears overflow.
- **stall_out** = (count >= DEPTH-1), combinational from count. The one-entry slack absorbs the upstream one-cycle reaction delay.
- **FSM: IDLE, REQ, WAIT.**
  - IDLE: when count > 0, go to REQ.
  - REQ: arbiter_req = 1 and resource_input = FIFO head.
    - On arbiter_grant: pop the head, clear the latency counter, go to WAIT.
    - Else increment the timeout counter. On the cycle it reaches GRANT_TO: pop the head, pulse timeout_err, go to IDLE.
  - WAIT: the latency counter counts to RES_LAT. In the cycle it reaches RES_LAT, capture resource_output into result. result_valid is set for the next cycle. Go to REQ if count > 0 (evaluated after this cycle's push/pop), else IDLE.
- resource_input holds the last driven word outside REQ. arbiter_req is 0 outside REQ.
- The timeout counter clears on entry to REQ.
- **flush.** FIFO empties, FSM goes to IDLE, all counters clear. No result_valid is produced for the in-flight word, and any same-cycle in_valid is ignored. flush does not clear overflow.
- **reset.** Same as flush, plus overflow = 0.

## Timing
- Reset values:
  - stall_out 0, arbiter_req 0, resource_input 0, result 0.
  - result_valid 0, timeout_err 0, overflow 0.
  - FSM IDLE, count 0.
- Pipeline, with the word accepted in cycle C into an empty FIFO and the FSM in IDLE:
  - count = 1 in C+1.
  - REQ (arbiter_req high) from C+2.
  - Grant in cycle T ≥ C+2: WAIT from T+1.
  - resource_output sampled at the edge ending cycle T+RES_LAT.
  - result_valid high in cycle T+RES_LAT+1.
- Back-to-back: arbiter_req re-asserts in T+RES_LAT+1, the same cycle as result_valid. Throughput is 1 word per RES_LAT+1 cycles under continuous grant.
- A grant seen outside REQ is ignored.
- Timeout: first REQ cycle R. With no grant, timeout_err is high in cycle R+GRANT_TO and the FSM is IDLE in R+GRANT_TO+1.
- Simultaneous push and pop when full: both take effect and count is unchanged.
- flush or reset asserted mid-WAIT: outputs take reset values (except overflow under flush) in the next cycle.

## Test plan
- **Single word.** Reset, then push 0xA5A5_0001 at C; grant tied high; resource_output = 0x1234_5678 in WAIT. Required: arbiter_req in C+2; result = 0x1234_5678 with result_valid in C+5 (RES_LAT=2).
- **Fill and stall.** Grant low, push 4 words on consecutive cycles. Required: stall_out high once count = 3. A 5th push sets overflow with count still 4. Then grant high: the 4 words drain in FIFO order with one result every 3 cycles.
- **Grant timeout.** Push 0x0000_00FF, never grant. Required: timeout_err pulse 15 cycles after REQ entry; count 0; no result_valid.
- **Flush mid-WAIT.** Grant one word, assert flush in T+1. Required: no result_valid; arbiter_req 0, count 0 in T+2; overflow unchanged.
- **Push and pop at full.** Push at count = 4 in the grant cycle. Required: count stays 4 and the new word is the last one dequeued.
- **Reset mid-operation.** Assert reset in REQ with overflow = 1. Required: all outputs at reset values in the next cycle, including overflow = 0.

Source files
------------

// File: rtl/resource_arbiter_if.sv
// resource_arbiter_if: queues validated pipeline words, arbitrates for a shared
// resource, drives each word to it and returns the result after a fixed latency.
module resource_arbiter_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RES_LAT  = 2,
  parameter int unsigned GRANT_TO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              stall_out,
  output logic              arbiter_req,
  input  logic              arbiter_grant,
  output logic [DATA_W-1:0] resource_input,
  input  logic [DATA_W-1:0] resource_output,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              timeout_err,
  output logic              overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = $clog2(RES_LAT + 1);
  localparam int unsigned TO_W  = $clog2(GRANT_TO + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [LAT_W-1:0]  lat_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic              full_c;
  logic              pop_c;
  logic              push_c;
  logic              to_hit_c;
  logic [CNT_W-1:0]  count_next_c;
  logic [DATA_W-1:0] head_next_c;

  // Queue control: pops only happen in REQ (grant or timeout drop).
  always_comb begin
    full_c       = (count == CNT_W'(DEPTH));
    to_hit_c     = (to_cnt == TO_W'(GRANT_TO - 1));
    pop_c        = (state == S_REQ) && (arbiter_grant || to_hit_c);
    push_c       = in_valid && !flush && (!full_c || pop_c);
    count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
    // Head after this cycle's update, used only in non-popping states;
    // an empty queue receiving a push exposes the incoming word directly.
    head_next_c  = (count == '0) ? in_data : mem[rd_ptr];
  end

  // One entry of slack covers the upstream one-cycle stall reaction.
  assign stall_out = (count >= CNT_W'(DEPTH - 1));

  // FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_c && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next_c;
    end
  end

  // Sticky drop flag; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (!flush && in_valid && full_c && !pop_c) begin
      overflow <= 1'b1;
    end
  end

  // Request/grant/latency sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state          <= S_IDLE;
      arbiter_req    <= 1'b0;
      resource_input <= '0;
      result         <= '0;
      result_valid   <= 1'b0;
      timeout_err    <= 1'b0;
      lat_cnt        <= '0;
      to_cnt         <= '0;
    end else begin
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state          <= S_REQ;
            arbiter_req    <= 1'b1;
            resource_input <= mem[rd_ptr];
            to_cnt         <= '0;
          end
        end
        S_REQ: begin
          if (arbiter_grant) begin
            state       <= S_WAIT;
            arbiter_req <= 1'b0;
            lat_cnt     <= '0;
          end else if (to_hit_c) begin
            state       <= S_IDLE;
            arbiter_req <= 1'b0;
            timeout_err <= 1'b1;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_W'(RES_LAT - 1)) begin
            result       <= resource_output;
            result_valid <= 1'b1;
            lat_cnt      <= '0;
            if (count_next_c != '0) begin
              state          <= S_REQ;
              arbiter_req    <= 1'b1;
              resource_input <= head_next_c;
              to_cnt         <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: begin
          state       <= S_IDLE;
          arbiter_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resource_arbiter_if.sv
// Directed bench for resource_arbiter_if (DEPTH=4, RES_LAT=2, GRANT_TO=15).
module tb_resource_arbiter_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        stall_out;
  logic        arbiter_req;
  logic        arbiter_grant;
  logic [31:0] resource_input;
  logic [31:0] resource_output;
  logic [31:0] result;
  logic        result_valid;
  logic        timeout_err;
  logic        overflow;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] w [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
  logic [31:0] p [5] = '{32'h5000_0000, 32'h5000_0011, 32'h5000_0022, 32'h5000_0033, 32'h5000_0044};

  resource_arbiter_if #(
    .DATA_W(32), .DEPTH(4), .RES_LAT(2), .GRANT_TO(15)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .stall_out       (stall_out),
    .arbiter_req     (arbiter_req),
    .arbiter_grant   (arbiter_grant),
    .resource_input  (resource_input),
    .resource_output (resource_output),
    .result          (result),
    .result_valid    (result_valid),
    .timeout_err     (timeout_err),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0;
    arbiter_grant = 1'b0; resource_output = '0;
    tick(); tick();

    // Reset values
    check1 ("rst_stall",  stall_out, 1'b0);
    check1 ("rst_req",    arbiter_req, 1'b0);
    check32("rst_rin",    resource_input, 32'h0);
    check32("rst_result", result, 32'h0);
    check1 ("rst_rv",     result_valid, 1'b0);
    check1 ("rst_to",     timeout_err, 1'b0);
    check1 ("rst_ovf",    overflow, 1'b0);
    check32("rst_count",  32'(dut.count), 32'd0);
    reset = 1'b0;

    // Single word, grant tied high (also high while not in REQ)
    in_valid = 1'b1; in_data = 32'hA5A5_0001; arbiter_grant = 1'b1;
    resource_output = 32'h1234_5678;
    tick();                                   // C+1
    in_valid = 1'b0;
    check32("t1_count_c1", 32'(dut.count), 32'd1);
    check1 ("t1_req_c1", arbiter_req, 1'b0);
    tick();                                   // C+2
    check1 ("t1_req_c2", arbiter_req, 1'b1);
    check32("t1_rin_c2", resource_input, 32'hA5A5_0001);
    tick();                                   // C+3
    check1 ("t1_req_c3", arbiter_req, 1'b0);
    tick();                                   // C+4
    check1 ("t1_rv_c4", result_valid, 1'b0);
    tick();                                   // C+5
    check1 ("t1_rv_c5", result_valid, 1'b1);
    check32("t1_res_c5", result, 32'h1234_5678);
    check1 ("t1_req_c5", arbiter_req, 1'b0);
    tick();                                   // C+6
    check1 ("t1_rv_c6", result_valid, 1'b0);
    arbiter_grant = 1'b0;

    // Fill, stall, overflow, then drain in order
    in_valid = 1'b1; in_data = w[0];
    tick();                                   // C+1
    check32("t2_count1", 32'(dut.count), 32'd1);
    check1 ("t2_stall1", stall_out, 1'b0);
    in_data = w[1];
    tick();                                   // C+2
    check1 ("t2_stall2", stall_out, 1'b0);
    in_data = w[2];
    tick();                                   // C+3
    check32("t2_count3", 32'(dut.count), 32'd3);
    check1 ("t2_stall3", stall_out, 1'b1);
    in_data = w[3];
    tick();                                   // C+4
    check32("t2_count4", 32'(dut.count), 32'd4);
    check1 ("t2_ovf_pre", overflow, 1'b0);
    in_data = 32'hDEAD_BEEF;
    tick();                                   // C+5
    in_valid = 1'b0;
    check1 ("t2_ovf", overflow, 1'b1);
    check32("t2_count_ovf", 32'(dut.count), 32'd4);
    check1 ("t2_stall4", stall_out, 1'b1);
    arbiter_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check1 ("t2_req", arbiter_req, 1'b1);
      check32("t2_rin", resource_input, w[k]);
      resource_output = 32'hB000_0000 + 32'(k);
      tick(); tick(); tick();
      check1 ("t2_rv", result_valid, 1'b1);
      check32("t2_res", result, 32'hB000_0000 + 32'(k));
    end
    check1 ("t2_req_end", arbiter_req, 1'b0);
    arbiter_grant = 1'b0;

    // Grant timeout
    in_valid = 1'b1; in_data = 32'h0000_00FF;
    tick();                                   // C+1
    in_valid = 1'b0;
    tick();                                   // R
    check1 ("t3_req_r", arbiter_req, 1'b1);
    check32("t3_rin_r", resource_input, 32'h0000_00FF);
    repeat (14) tick();                       // R+14
    check1 ("t3_to_r14", timeout_err, 1'b0);
    check1 ("t3_req_r14", arbiter_req, 1'b1);
    tick();                                   // R+15
    check1 ("t3_to_r15", timeout_err, 1'b1);
    check1 ("t3_req_r15", arbiter_req, 1'b0);
    check32("t3_count_r15", 32'(dut.count), 32'd0);
    check1 ("t3_rv_r15", result_valid, 1'b0);
    tick();                                   // R+16
    check1 ("t3_to_r16", timeout_err, 1'b0);
    check1 ("t3_ovf_sticky", overflow, 1'b1);

    // Flush in T+1 (first WAIT cycle), with a same-cycle push that must be ignored
    in_valid = 1'b1; in_data = 32'h7777_0007; arbiter_grant = 1'b1;
    resource_output = 32'h9999_9999;
    tick();                                   // C+1
    in_valid = 1'b0;
    tick();                                   // C+2 = T
    check1 ("t4_req_t", arbiter_req, 1'b1);
    tick();                                   // T+1
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hBAD0_0001;
    tick();                                   // T+2
    flush = 1'b0; in_valid = 1'b0; arbiter_grant = 1'b0;
    check1 ("t4_rv_t2", result_valid, 1'b0);
    check1 ("t4_req_t2", arbiter_req, 1'b0);
    check32("t4_count_t2", 32'(dut.count), 32'd0);
    check1 ("t4_ovf_t2", overflow, 1'b1);
    check32("t4_result_t2", result, 32'h0);
    tick();                                   // T+3
    check1 ("t4_rv_t3", result_valid, 1'b0);
    check1 ("t4_req_t3", arbiter_req, 1'b0);

    // Push and pop in the same cycle at full
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = p[k];
      tick();
    end                                       // C+4, count 4, REQ
    in_valid = 1'b0;
    check32("t5_count_pre", 32'(dut.count), 32'd4);
    arbiter_grant = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check1 ("t5_req", arbiter_req, 1'b1);
      check32("t5_rin", resource_input, p[k]);
      resource_output = 32'hC000_0000 + 32'(k);
      if (k == 0) begin
        in_valid = 1'b1; in_data = p[4];
      end
      tick();
      in_valid = 1'b0;
      if (k == 0) check32("t5_count_full", 32'(dut.count), 32'd4);
      tick(); tick();
      check1 ("t5_rv", result_valid, 1'b1);
      check32("t5_res", result, 32'hC000_0000 + 32'(k));
    end
    check32("t5_count_end", 32'(dut.count), 32'd0);
    arbiter_grant = 1'b0;

    // Reset while in REQ with overflow set
    in_valid = 1'b1; in_data = 32'h6666_0006;
    tick();
    in_valid = 1'b0;
    tick();
    check1 ("t6_req_pre", arbiter_req, 1'b1);
    check1 ("t6_ovf_pre", overflow, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1 ("t6_req", arbiter_req, 1'b0);
    check32("t6_rin", resource_input, 32'h0);
    check32("t6_result", result, 32'h0);
    check1 ("t6_rv", result_valid, 1'b0);
    check1 ("t6_to", timeout_err, 1'b0);
    check1 ("t6_ovf", overflow, 1'b0);
    check1 ("t6_stall", stall_out, 1'b0);
    check32("t6_count", 32'(dut.count), 32'd0);
    tick();
    check1 ("t6_req_after", arbiter_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
